seg7_scan8: RTL and testbench
=============================

# seg7_scan8

Eight-digit multiplexed seven-segment scan driver, directly downstream of the 8-channel display multiplexer. It takes the selected 32-bit display number, per-digit blink enables and per-digit decimal points. It time-multiplexes the digits onto active-low anode and segment lines with frame-coherent snapshotting, blinking and inter-digit blanking.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; minimum 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- Disp_num  in  32  hex value to display; digit i shows Disp_num[4i+3:4i], digit 0 rightmost.
- LE  in  8  blink enable; bit i = 1 makes digit i blink.
- point  in  8  decimal point; bit i = 1 lights the dp of digit i.
- AN  out  8  anode select, active-low, one-hot-low when a digit is lit.
- SEGMENT  out  8  {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1. Digit index `dig` runs 0..7.
  - When cnt==SCAN_DIV-1: cnt←0 and dig←dig+1.
  - dig wraps 7→0.
- Blink counter runs 0..BLINK_DIV-1. At the wrap, `phase` toggles. phase=0 means visible.
- Snapshot: on any clock edge with cnt==0 && dig==0, snap_num←Disp_num, snap_le←LE and snap_pt←point.
  - Input changes mid-frame never affect the current frame.
- Output register, updated every clock edge:
  - cnt==0: AN←8'hFF and SEGMENT←8'hFF. This is the anti-ghosting blank at the start of every slot.
  - cnt≥1 and (snap_le[dig] && phase): AN←8'hFF and SEGMENT←8'hFF. The digit is blinked off, dp included.
  - Otherwise: AN←~(8'b1<<dig), SEGMENT[6:0]←hex pattern of snap_num[4dig+3:4dig], and SEGMENT[7]←~snap_pt[dig].
- Hex patterns (SEGMENT[6:0] with dp off, shown as full byte): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Reset (rst high at an edge): cnt=0, dig=0, phase=0, blink counter=0, snapshot=0, AN=8'hFF, SEGMENT=8'hFF.
- First edge after reset: snapshot loads and outputs stay blank. The second edge shows digit 0 of the new snapshot.
- Output latency is one cycle from (cnt, dig, phase, snapshot) state. A digit is lit for SCAN_DIV-1 cycles per slot.
- Frame length is 8·SCAN_DIV cycles. An input change becomes visible within at most one frame plus 2 cycles.
- A phase toggle mid-slot takes effect on the next edge. There is no alignment to frame boundaries.
- Reset mid-frame: all state clears regardless of cnt/dig. Scanning restarts at digit 0 with a fresh snapshot.
- Simultaneous slot wrap and blink wrap: both take effect on the same edge.

## Structure
- Shared package/include holds:
  - the 16-entry hex→7-segment active-low pattern constants;
  - the blank constant 8'hFF.
- One combinational sub-module, `hex_to_seg7` (4-bit in, 7-bit active-low out), reused by other display blocks.
- Parameter sanity: elaboration error if SCAN_DIV<2 or BLINK_DIV<1.

## Test plan
Bench parameters are SCAN_DIV=4 and BLINK_DIV=64.
- Reset: hold rst for 3 cycles with arbitrary inputs → AN=FF and SEGMENT=FF throughout. After release, 2 more cycles of FF/FF, then digit 0.
- Basic scan: Disp_num=32'h76543210, LE=0, point=0 → per slot, 1 cycle FF/FF, then 3 cycles of the lit digit:
  - digit 0: AN=FE, SEGMENT=C0
  - digit 1: AN=FD, SEGMENT=F9
  - digit 7: AN=7F, SEGMENT=F8
  - then wraps to digit 0.
- Snapshot coherence: switch Disp_num to 32'hFFFFFFFF while dig=3 → digits 3..7 still show 3..7 this frame. Next frame shows SEGMENT=8E on every digit.
- Decimal point: Disp_num=0, point=8'h81 → digits 0 and 7 show SEGMENT=40. Others show C0.
- Blink: LE=8'h04 → digit 2 slots read AN=FF and SEGMENT=FF while phase=1 (64-cycle windows). Digit 2 shows normally while phase=0. Other digits are unaffected.
- Reset mid-frame: assert rst for 1 cycle while dig=5 → FF/FF, then scan restarts at digit 0 with the snapshot reloaded from current inputs and the blink phase cleared.

Source files
------------

// File: rtl/seg7_scan8_pkg.sv
// Shared constants for the seven-segment display blocks: active-low hex glyphs
// and the all-off code used for blanking.
package seg7_scan8_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_BLANK  = 8'hFF;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment. Entry 15 is listed first.
  localparam logic [15:0][6:0] HEX_SEG_TAB = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg7_scan8_hex.sv
// Hex nibble to active-low seven-segment glyph; purely combinational so other
// display blocks can reuse it.
module hex_to_seg7
  import seg7_scan8_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG_TAB[i_hex];

endmodule

// File: rtl/seg7_scan8.sv
// Eight-digit multiplexed seven-segment scan driver with frame-coherent
// snapshotting, per-digit blinking and a blank cycle at the start of each slot.
module seg7_scan8
  import seg7_scan8_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  LE,
  input  logic [7:0]  point,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT
);

  localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  generate
    if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg7_scan8: SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("seg7_scan8: BLINK_DIV must be at least 1");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_dig;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [31:0]   r_snap_num;
  logic [7:0]    r_snap_le;
  logic [7:0]    r_snap_pt;
  logic [7:0]    r_an;
  logic [7:0]    r_seg;

  logic          w_cnt_wrap;
  logic          w_blink_wrap;
  logic          w_frame_start;
  logic [3:0]    w_nibble;
  logic [6:0]    w_glyph;
  logic [7:0]    w_an_nxt;
  logic [7:0]    w_seg_nxt;

  assign w_cnt_wrap    = (r_cnt == CNT_LAST);
  assign w_blink_wrap  = (r_bcnt == BLINK_LAST);
  assign w_frame_start = (r_cnt == '0) && (r_dig == 3'd0);
  assign w_nibble      = r_snap_num[{r_dig, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .i_hex (w_nibble),
    .o_seg (w_glyph)
  );

  // Slot counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_dig <= 3'd0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_dig <= r_dig + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Free-running blink timebase, deliberately not aligned to frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_blink_wrap) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  // Inputs are captured once per frame so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_num <= '0;
      r_snap_le  <= '0;
      r_snap_pt  <= '0;
    end else if (w_frame_start) begin
      r_snap_num <= Disp_num;
      r_snap_le  <= LE;
      r_snap_pt  <= point;
    end
  end

  always_comb begin
    w_an_nxt  = AN_BLANK;
    w_seg_nxt = SEG_BLANK;
    if (r_cnt != '0 && !(r_snap_le[r_dig] && r_phase)) begin
      w_an_nxt  = ~(8'b1 << r_dig);
      w_seg_nxt = {~r_snap_pt[r_dig], w_glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign AN      = r_an;
  assign SEGMENT = r_seg;

endmodule

// File: tb/tb_seg7_scan8.sv
// Directed bench for seg7_scan8 with SCAN_DIV=4, BLINK_DIV=64: every cycle is
// checked against a spec-level expectation, plus hand-computed spot values.
module tb_seg7_scan8;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  // Active-low {g..a} glyphs for 0..F.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Disp_num;
  logic [7:0]  LE;
  logic [7:0]  point;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  logic [31:0] s_num;
  logic [7:0]  s_le;
  logic [7:0]  s_pt;
  logic [15:0] exp_q[$];

  seg7_scan8 #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Disp_num (Disp_num),
    .LE       (LE),
    .point    (point),
    .AN       (AN),
    .SEGMENT  (SEGMENT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s t=%0d: got AN/SEG=%h expected %h", tag, t, obs, exp);
  endtask

  // Output produced by the edge with global index tt (t counts edges since reset release).
  function automatic logic [15:0] model_out(input int tt);
    int         d;
    logic [7:0] an_e;
    d = (tt / SCAN_DIV) % 8;
    if (tt % SCAN_DIV == 0) return 16'hFFFF;
    if (s_le[d] && ((tt / BLINK_DIV) % 2 == 1)) return 16'hFFFF;
    an_e = ~(8'b1 << d);
    return {an_e, ~s_pt[d], SEG_TAB[s_num[4*d +: 4]]};
  endfunction

  task automatic cyc();
    if (t % (8 * SCAN_DIV) == 0) begin
      s_num = Disp_num;
      s_le  = LE;
      s_pt  = point;
    end
    exp_q.push_back(model_out(t));
    @(posedge clk);
    #1;
    check("scan", {AN, SEGMENT}, exp_q.pop_front());
    t++;
  endtask

  task automatic run_until(input int tt);
    while (t < tt) cyc();
  endtask

  task automatic spot(input string tag, input logic [15:0] exp);
    check(tag, {AN, SEGMENT}, exp);
  endtask

  initial begin
    rst      = 1'b1;
    Disp_num = 32'hDEADBEEF;
    LE       = 8'hFF;
    point    = 8'h55;
    s_num    = '0;
    s_le     = '0;
    s_pt     = '0;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", {AN, SEGMENT}, 16'hFFFF);
    end

    Disp_num = 32'h76543210;
    LE       = 8'h00;
    point    = 8'h00;
    rst      = 1'b0;
    spot("post_release", 16'hFFFF);

    // Basic scan over two frames.
    run_until(1);  spot("first_edge_blank", 16'hFFFF);
    run_until(2);  spot("dig0", 16'hFEC0);
    run_until(6);  spot("dig1", 16'hFDF9);
    run_until(30); spot("dig7", 16'h7FF8);
    run_until(33); spot("slot_blank", 16'hFFFF);
    run_until(34); spot("wrap_dig0", 16'hFEC0);

    // Snapshot coherence: change input during the digit-3 slot.
    run_until(77);
    Disp_num = 32'hFFFFFFFF;
    run_until(94); spot("coh_dig7", 16'h7FF8);
    run_until(98); spot("coh_next", 16'hFE8E);

    // Decimal points on digits 0 and 7.
    run_until(128);
    Disp_num = 32'h00000000;
    point    = 8'h81;
    run_until(130); spot("dp_dig0", 16'hFE40);
    run_until(134); spot("dp_dig1", 16'hFDC0);
    run_until(158); spot("dp_dig7", 16'h7F40);

    // Blink on digit 2 across phase windows.
    run_until(160);
    Disp_num = 32'h76543210;
    point    = 8'h00;
    LE       = 8'h04;
    run_until(170); spot("blink_vis", 16'hFBA4);
    run_until(202); spot("blink_off", 16'hFFFF);
    run_until(206); spot("blink_other", 16'hF7B0);
    run_until(266); spot("blink_back", 16'hFBA4);

    // Reset mid-frame while dig=5 and phase=1.
    run_until(342);
    rst      = 1'b1;
    Disp_num = 32'h89ABCDEF;
    @(posedge clk);
    #1;
    check("mid_reset", {AN, SEGMENT}, 16'hFFFF);
    rst   = 1'b0;
    t     = 0;
    s_num = '0;
    s_le  = '0;
    s_pt  = '0;
    run_until(1);  spot("restart_blank", 16'hFFFF);
    run_until(2);  spot("restart_dig0", 16'hFE8E);
    run_until(10); spot("phase_cleared", 16'hFBA1);
    run_until(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
